// File: rtl/baud_gen_pkg.sv
// Shared constants for the fractional baud generator: legal minimum period,
// common 12 MHz rate settings and the quadrant encoding of the phase output.
package baud_gen_pkg;

  localparam int MIN_DIV = 4;

  localparam int DIV_DSHOT600   = 20;
  localparam int DIV_DSHOT300   = 40;
  localparam int DIV_DSHOT150   = 80;
  localparam int DIV_UART115200 = 104;
  localparam int FRAC_115200    = 43;  // 104 + 43/256 = 104.17

  localparam logic [1:0] PHASE_Q0 = 2'd0;
  localparam logic [1:0] PHASE_Q1 = 2'd1;
  localparam logic [1:0] PHASE_Q2 = 2'd2;
  localparam logic [1:0] PHASE_Q3 = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } bg_state_e;

endpackage

// File: rtl/baud_gen_frac_if.sv
// Rate configuration port: valid/ready transfer of an integer divisor plus
// fractional numerator; the generator is the slave side.
interface baud_gen_frac_if #(
  parameter int DIV_W  = 24,
  parameter int FRAC_W = 8
);
  import baud_gen_pkg::*;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [DIV_W-1:0]  cfg_div;
  logic [FRAC_W-1:0] cfg_frac;

  modport master (output cfg_valid, output cfg_div, output cfg_frac, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_div, input cfg_frac, output cfg_ready);

endinterface

// File: rtl/baud_frac_acc.sv
// Fractional accumulator: steps by frac on each tick, cleared on apply/idle.
// carry is combinational and describes the period that starts after this edge.
module baud_frac_acc #(
  parameter int FRAC_W = 8
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);
  import baud_gen_pkg::*;

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] acc_nxt;
  logic [FRAC_W:0]   sum;

  always_comb begin
    acc_nxt = acc;
    if (clear) begin
      acc_nxt = '0;
    end else if (step) begin
      acc_nxt = acc + frac;
    end
  end

  // When step is set without clear, frac equals the running frac, so one
  // input serves both the update and the look-ahead carry.
  assign sum   = {1'b0, acc_nxt} + {1'b0, frac};
  assign carry = sum[FRAC_W];

  always_ff @(posedge clk_in) begin
    if (reset) begin
      acc <= '0;
    end else begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-N baud tick generator with half/quarter strobes and on-the-fly rate change.
// Strobes decode registered count/thresholds (zero latency); cfg_ready low while a config is pending.
module baud_gen_frac #(
  parameter int DIV_W        = 24,
  parameter int FRAC_W       = 8,
  parameter int DEFAULT_DIV  = 80,
  parameter int DEFAULT_FRAC = 0,
  parameter int MIN_DIV      = baud_gen_pkg::MIN_DIV
) (
  input  logic           clk_in,
  input  logic           reset,
  input  logic           enable,
  input  logic           align_mid,
  baud_gen_frac_if.slave cfg,
  output logic           cfg_applied,
  output logic           tick,
  output logic           tick_half,
  output logic           tick_quarter,
  output logic [1:0]     phase,
  output logic           active
);
  import baud_gen_pkg::*;

  localparam int CW      = DIV_W + 1;
  localparam int RST_DIV = (DEFAULT_DIV < MIN_DIV) ? MIN_DIV : DEFAULT_DIV;

  bg_state_e         state;
  logic [CW-1:0]     cnt, cnt_p1;
  logic [CW-1:0]     p_thr, h_thr, q_thr, hq_thr;
  logic [CW-1:0]     p_nxt, h_nxt, q_nxt;
  logic [DIV_W-1:0]  act_div, pend_div, cfg_div_c, nxt_div;
  logic [FRAC_W-1:0] act_frac, pend_frac, nxt_frac;
  logic              pend_vld, run, accept, bypass, apply_pend;
  logic              acc_clear, carry, start_period;

  assign run    = (state == ST_RUN);
  assign active = run;
  assign cnt_p1 = cnt + CW'(1);

  assign tick         = run && (cnt_p1 == p_thr);
  assign tick_half    = run && (cnt_p1 == h_thr);
  assign tick_quarter = run && ((cnt_p1 == q_thr) || (cnt_p1 == hq_thr));

  assign cfg.cfg_ready = !pend_vld;
  assign accept        = cfg.cfg_valid && !pend_vld;
  assign bypass        = accept && tick;
  // Leaving RUN is an apply point too, so a pending rate is never stranded.
  assign apply_pend    = pend_vld && (!run || tick || !enable);
  assign cfg_applied   = apply_pend || bypass;
  assign cfg_div_c     = (cfg.cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg.cfg_div;

  always_comb begin
    nxt_div  = act_div;
    nxt_frac = act_frac;
    if (bypass) begin
      nxt_div  = cfg_div_c;
      nxt_frac = cfg.cfg_frac;
    end else if (apply_pend) begin
      nxt_div  = pend_div;
      nxt_frac = pend_frac;
    end
  end

  always_comb begin
    phase = PHASE_Q0;
    if (run) begin
      if (cnt < q_thr)       phase = PHASE_Q0;
      else if (cnt < h_thr)  phase = PHASE_Q1;
      else if (cnt < hq_thr) phase = PHASE_Q2;
      else                   phase = PHASE_Q3;
    end
  end

  assign acc_clear    = cfg_applied || !run || !enable;
  assign start_period = enable && (!run || tick);
  assign p_nxt        = {1'b0, nxt_div} + CW'(carry);
  assign h_nxt        = p_nxt >> 1;
  assign q_nxt        = p_nxt >> 2;

  baud_frac_acc #(.FRAC_W(FRAC_W)) u_acc (
    .clk_in (clk_in),
    .reset  (reset),
    .clear  (acc_clear),
    .step   (tick),
    .frac   (nxt_frac),
    .carry  (carry)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      p_thr     <= '0;
      h_thr     <= '0;
      q_thr     <= '0;
      hq_thr    <= '0;
      act_div   <= DIV_W'(RST_DIV);
      act_frac  <= FRAC_W'(DEFAULT_FRAC);
      pend_vld  <= 1'b0;
      pend_div  <= '0;
      pend_frac <= '0;
    end else begin
      if (cfg_applied) begin
        act_div  <= nxt_div;
        act_frac <= nxt_frac;
      end
      if (apply_pend) begin
        pend_vld <= 1'b0;
      end else if (accept && !bypass) begin
        pend_vld  <= 1'b1;
        pend_div  <= cfg_div_c;
        pend_frac <= cfg.cfg_frac;
      end
      if (start_period) begin
        p_thr  <= p_nxt;
        h_thr  <= h_nxt;
        q_thr  <= q_nxt;
        hq_thr <= h_nxt + q_nxt;
      end
      if (!run) begin
        if (enable) begin
          state <= ST_RUN;
          cnt   <= align_mid ? h_nxt : '0;
        end
      end else if (!enable) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else if (tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt_p1;
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench: expected strobe cycles come from a closed-form period model
// and are popped by a monitor whenever the DUT pulses an output.
module tb_baud_gen_frac;
  import baud_gen_pkg::*;

  localparam int    DIV_W  = 24;
  localparam int    FRAC_W = 8;
  localparam longint INF   = 64'd1 << 40;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       enable, align_mid;
  logic       cfg_applied, tick, tick_half, tick_quarter, active;
  logic [1:0] phase;

  baud_gen_frac_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) cfg ();

  baud_gen_frac #(
    .DIV_W(DIV_W), .FRAC_W(FRAC_W), .DEFAULT_DIV(80), .DEFAULT_FRAC(0), .MIN_DIV(MIN_DIV)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .enable       (enable),
    .align_mid    (align_mid),
    .cfg          (cfg),
    .cfg_applied  (cfg_applied),
    .tick         (tick),
    .tick_half    (tick_half),
    .tick_quarter (tick_quarter),
    .phase        (phase),
    .active       (active)
  );

  always #5 clk_in = ~clk_in;

  longint cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int n_ticks = 0;
  longint q_tick[$], q_half[$], q_qtr[$], q_app[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_check(input int kind);
    longint e;
    bit     empty;
    string  nm;
    empty = 1'b0;
    e = 0;
    case (kind)
      0: begin nm = "tick_cycle";    if (q_tick.size() == 0) empty = 1'b1; else e = q_tick.pop_front(); end
      1: begin nm = "half_cycle";    if (q_half.size() == 0) empty = 1'b1; else e = q_half.pop_front(); end
      2: begin nm = "quarter_cycle"; if (q_qtr.size()  == 0) empty = 1'b1; else e = q_qtr.pop_front();  end
      default: begin nm = "applied_cycle"; if (q_app.size() == 0) empty = 1'b1; else e = q_app.pop_front(); end
    endcase
    if (empty) begin
      checks++;
      errors++;
      $display("FAIL %s: pulse at cycle %0d, expected none", nm, cyc);
    end else begin
      chk(nm, cyc, e);
    end
  endtask

  // Monitor: every strobe must match the next expected cycle of its kind.
  always @(negedge clk_in) begin
    if (!reset) begin
      if (tick === 1'b1) begin
        n_ticks++;
        pop_check(0);
        chk("phase_at_tick", longint'(phase), 3);
      end
      if (tick_half === 1'b1) begin
        pop_check(1);
        chk("phase_at_half", longint'(phase), 1);
      end
      if (tick_quarter === 1'b1) pop_check(2);
      if (cfg_applied === 1'b1)  pop_check(3);
    end
  end

  task automatic emit(input int kind, input longint c, input longint lo, input longint hi);
    if (c >= lo && c < hi) begin
      case (kind)
        0: q_tick.push_back(c);
        1: q_half.push_back(c);
        default: q_qtr.push_back(c);
      endcase
    end
  endtask

  // Period k = D + floor((k+1)f/2^F) - floor(kf/2^F); events are pushed for
  // cycles in [run_start, win_hi). t_stop = first tick at or after stop_at.
  task automatic model_seg(input longint run_start, input bit al, input longint win_hi,
                           input longint stop_at, input int div, input int frac,
                           output longint t_stop);
    longint d, ps, p, h, q, k, m;
    m  = 64'd1 << FRAC_W;
    d  = (div < MIN_DIV) ? MIN_DIV : div;
    ps = al ? run_start - d / 2 : run_start;
    k  = 0;
    t_stop = -1;
    while (ps < win_hi && t_stop < 0) begin
      p = d + ((k + 1) * frac) / m - (k * frac) / m;
      h = p / 2;
      q = p / 4;
      emit(2, ps + q - 1, run_start, win_hi);
      emit(1, ps + h - 1, run_start, win_hi);
      emit(2, ps + h + q - 1, run_start, win_hi);
      emit(0, ps + p - 1, run_start, win_hi);
      if (ps + p - 1 >= stop_at) t_stop = ps + p - 1;
      ps = ps + p;
      k++;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_until(input longint c);
    while (cyc < c) next_cycle();
  endtask

  task automatic drain();
    chk("missing_ticks",    q_tick.size(), 0);
    chk("missing_halves",   q_half.size(), 0);
    chk("missing_quarters", q_qtr.size(),  0);
    chk("missing_applies",  q_app.size(),  0);
  endtask

  task automatic stop_run(input longint drop);
    wait_until(drop);
    enable = 1'b0;
    wait_until(drop + 1);
    chk("active_after_stop", longint'(active), 0);
    chk("phase_after_stop", longint'(phase), 0);
    chk("ready_after_stop", longint'(cfg.cfg_ready), 1);
    drain();
  endtask

  task automatic load_cfg(input int d, input int f);
    q_app.push_back(cyc + 1);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_div   = DIV_W'(d);
    cfg.cfg_frac  = FRAC_W'(f);
    next_cycle();
    cfg.cfg_valid = 1'b0;
    chk("ready_while_pending", longint'(cfg.cfg_ready), 0);
    next_cycle();
    chk("ready_after_idle_apply", longint'(cfg.cfg_ready), 1);
  endtask

  task automatic offer_cfg(input int d, input int f);
    chk("ready_at_offer", longint'(cfg.cfg_ready), 1);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_div   = DIV_W'(d);
    cfg.cfg_frac  = FRAC_W'(f);
    next_cycle();
    cfg.cfg_valid = 1'b0;
  endtask

  // Run at (d1,f1), offer (d2,f2) mid-run, then stop gap cycles after it lands.
  task automatic scenario(input int d1, input int f1, input bit al, input int off,
                          input int d2, input int f2, input int gap);
    longint start, offer, t_app, drop, unused;
    load_cfg(d1, f1);
    enable    = 1'b1;
    align_mid = al;
    start     = cyc + 1;
    offer     = start + off;
    model_seg(start, al, INF, offer, d1, f1, t_app);
    q_app.push_back(t_app);
    drop = t_app + 1 + gap;
    model_seg(t_app + 1, 1'b0, drop + 1, INF, d2, f2, unused);
    wait_until(offer);
    offer_cfg(d2, f2);
    chk("ready_after_offer", longint'(cfg.cfg_ready), (t_app == offer) ? 1 : 0);
    stop_run(drop);
    align_mid = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint start, drop, t, n0;
    enable        = 1'b0;
    align_mid     = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_div   = '0;
    cfg.cfg_frac  = '0;
    repeat (3) @(posedge clk_in);
    #1 reset = 1'b0;

    chk("rst_tick", longint'(tick), 0);
    chk("rst_half", longint'(tick_half), 0);
    chk("rst_quarter", longint'(tick_quarter), 0);
    chk("rst_applied", longint'(cfg_applied), 0);
    chk("rst_active", longint'(active), 0);
    chk("rst_phase", longint'(phase), 0);
    chk("rst_ready", longint'(cfg.cfg_ready), 1);

    // Reset defaults: 80-cycle period, phase walks quadrants of 20.
    enable = 1'b1;
    start  = cyc + 1;
    drop   = start + 405;
    model_seg(start, 1'b0, drop + 1, INF, DIV_DSHOT150, 0, t);
    while (cyc < drop) begin
      next_cycle();
      chk("phase_walk", longint'(phase), ((cyc - start) % 80) / 20);
    end
    stop_run(drop);

    // 80 + 128/256: 256 ticks in exactly 20608 cycles.
    load_cfg(80, 128);
    enable = 1'b1;
    start  = cyc + 1;
    model_seg(start, 1'b0, start + 20608, INF, 80, 128, t);
    n0 = n_ticks;
    stop_run(start + 20607);
    chk("ticks_in_20608", n_ticks - n0, 256);

    scenario(DIV_DSHOT600, 0, 1'b0, 25, DIV_DSHOT300, 0, 120);
    scenario(DIV_DSHOT150, 0, 1'b1, 150, DIV_DSHOT150, 0, 200);
    scenario(2, 0, 1'b0, 10, 3, 0, 40);
    scenario(DIV_UART115200, FRAC_115200, 1'b0, 300, 5, 200, 60);

    // Enable drop at cnt 30 with a pending config: apply wins, no tick.
    load_cfg(80, 0);
    enable = 1'b1;
    start  = cyc + 1;
    drop   = start + 30;
    model_seg(start, 1'b0, drop + 1, INF, 80, 0, t);
    q_app.push_back(drop);
    wait_until(start + 25);
    offer_cfg(50, 0);
    chk("ready_pending_run", longint'(cfg.cfg_ready), 0);
    wait_until(drop);
    chk("no_tick_at_drop", longint'(tick), 0);
    stop_run(drop);
    enable = 1'b1;
    start  = cyc + 1;
    model_seg(start, 1'b0, start + 120, INF, 50, 0, t);
    stop_run(start + 119);

    // Reset mid-run drops the pending config and restores the default rate.
    enable = 1'b1;
    start  = cyc + 1;
    model_seg(start, 1'b0, start + 12, INF, 50, 0, t);
    wait_until(start + 10);
    offer_cfg(30, 0);
    wait_until(start + 12);
    reset  = 1'b1;
    enable = 1'b0;
    next_cycle();
    reset = 1'b0;
    chk("mid_rst_tick", longint'(tick), 0);
    chk("mid_rst_half", longint'(tick_half), 0);
    chk("mid_rst_quarter", longint'(tick_quarter), 0);
    chk("mid_rst_applied", longint'(cfg_applied), 0);
    chk("mid_rst_active", longint'(active), 0);
    chk("mid_rst_phase", longint'(phase), 0);
    chk("mid_rst_ready", longint'(cfg.cfg_ready), 1);
    drain();
    enable = 1'b1;
    start  = cyc + 1;
    model_seg(start, 1'b0, start + 170, INF, 80, 0, t);
    stop_run(start + 169);

    for (int i = 0; i < 8; i++) begin
      scenario($urandom_range(2, 50), $urandom_range(0, 255), 1'($urandom_range(0, 1)),
               $urandom_range(0, 150), $urandom_range(2, 50), $urandom_range(0, 255),
               $urandom_range(0, 150));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
Runtime-programmable, fractional-N successor to the fixed-divisor baud tick generator. It produces bit-period ticks plus half- and quarter-period phase strobes for the DShot TX/RX and UART blocks. The divisor can be changed on the fly through a valid/ready config port, and a fractional accumulator gives exact average rates from the 12 MHz clock. A mid-bit start mode supports receiver sampling.

Parameters:
DIV_W, 24, width of integer divisor (covers 5 Hz at 12 MHz = 2 400 000)
FRAC_W, 8, width of fractional numerator (fraction = frac/2^FRAC_W)
DEFAULT_DIV, 80, integer divisor loaded at reset (DShot150 at 12 MHz)
DEFAULT_FRAC, 0, fractional numerator loaded at reset
MIN_DIV, 4, smallest legal period; smaller requests are clamped to MIN_DIV

Ports:
clk_in  in  1  system clock, 12 MHz
reset  in  1  synchronous, active-high
enable  in  1  run when high; low = idle, counter held at 0
align_mid  in  1  sampled on enable rising edge; 1 = first period is half length
cfg_valid  in  1  new rate offered
cfg_ready  out  1  config slot free; transfer when cfg_valid && cfg_ready
cfg_div  in  DIV_W  integer divisor
cfg_frac  in  FRAC_W  fractional numerator
cfg_applied  out  1  one-cycle pulse when a new config becomes active
tick  out  1  one-cycle pulse on the last cycle of each period
tick_half  out  1  one-cycle pulse at cnt == H-1
tick_quarter  out  1  one-cycle pulse at cnt == Q-1 and cnt == H+Q-1
phase  out  2  quadrant level: 0 cnt<Q, 1 cnt<H, 2 cnt<H+Q, 3 otherwise
active  out  1  high while counting

Behaviour:
- Reset: active config = {max(DEFAULT_DIV,MIN_DIV), DEFAULT_FRAC}; pending empty; cnt=0; acc=0. Outputs after reset: tick, tick_half, tick_quarter, cfg_applied, active = 0; phase = 0; cfg_ready = 1.
- Period P = D + carry, where D = active div and carry = overflow of acc + frac (FRAC_W-bit add). acc updates at each tick; P is computed at the start of each period. H = P>>1, Q = P>>2; thresholds are registered per period.
- Counter: while enable=1, cnt increments by 1 each cycle. At cnt == P-1, tick = 1 and cnt wraps to 0 on the next cycle.
- Enable rising edge (states IDLE -> RUN): acc=0. If align_mid=1, cnt is preloaded to H so the first tick arrives after P-H cycles; otherwise cnt starts at 0. active goes high on the same cycle.
- enable low (RUN -> IDLE): next cycle cnt=0, acc=0, all strobes 0, phase=0, active=0. A partial period is discarded with no tick.
- Config handshake: an accepted config goes to the pending register; cfg_ready=0 while pending is full.
  - Pending is applied on the cycle tick fires; the new D is used for the next period and acc is cleared.
  - If IDLE, pending is applied the cycle after acceptance.
  - Acceptance in the same cycle as tick bypasses pending and applies immediately.
  - cfg_applied pulses on the apply cycle. cfg_div < MIN_DIV is clamped on acceptance.
- Simultaneous enable fall and pending apply: the apply wins, so the config becomes active and cfg_applied pulses.
- Reset mid-period: everything returns to reset values, and the pending config is dropped.
- Width rules: cnt and thresholds are DIV_W+1 bits, so P = 2^DIV_W - 1 + 1 does not overflow. acc is FRAC_W bits with a carry-out.

Decomposition:
- Package baud_gen_pkg holds:
  - MIN_DIV
  - rate constants at 12 MHz: DIV_DSHOT600=20, DIV_DSHOT300=40, DIV_DSHOT150=80, DIV_UART115200=104 with FRAC_115200=43 (104.17)
  - the phase encoding constants
- One sub-module, baud_frac_acc: the fractional accumulator. Inputs are the frac value, a step strobe (tick) and a clear; it outputs carry for the next period.

Test Plan:
- Reset, enable=1, defaults 80/0 -> tick every 80 cycles. tick_half at cnt 39, tick_quarter at cnt 19 and 59; phase steps 0,1,2,3 at cnt 0/20/40/60.
- cfg_div=80, cfg_frac=128 (FRAC_W=8), enable -> periods alternate 80,81,80,81; 256 ticks take exactly 20 608 cycles.
- While running at 20/0, offer 40/0 mid-period -> cfg_ready drops. The current 20-cycle period completes, cfg_applied pulses coincident with its tick, the next period is 40 cycles, and cfg_ready returns high.
- align_mid=1, enable rise at 80/0 -> first tick 40 cycles after the rise, then every 80 cycles.
- cfg_div=2 -> clamped to 4: tick every 4 cycles, tick_half at cnt 1, tick_quarter at cnt 0 and 2.
- Drop enable at cnt 30 of an 80-cycle period with a pending config -> no tick, cfg_applied pulses, active=0 and phase=0 next cycle. Asserting reset mid-run returns all outputs to their reset values.
